// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use / branch stalls, a data-memory wait FSM with sticky timeout,
// and saturating stall/flush event counters.
//
// Handshake: the M-stage access (MemtoRegM or MemWriteM) is the request and
// mem_ready is the completion strobe; the access is done in the cycle where
// both are high, otherwise the whole pipe holds and the W stage takes a bubble.
//
// fsm_state is a debug view of the wait FSM: 0 = RUN, 1 = MEM_WAIT, 2 = ERR.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_err_nxt;
  logic              lwstall, branchstall, memstall, mem_pend;

  assign fsm_state = state;

  // Hazard conditions; lwstall compares raw register numbers with no zero guard.
  assign lwstall  = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
  assign branchstall = BranchD &
    ((RegWriteE & (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
     (MemtoRegM & (WriteRegM != 5'd0) & ((WriteRegM == RsD) | (WriteRegM == RtD))));
  assign mem_pend = (MemtoRegM | MemWriteM) & ~mem_ready;
  assign memstall = mem_pend | (state == ERR);

  // Forwarding selects: M beats W, register 0 never forwards, all zero in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (reset) begin
      if ((RsE != 5'd0) && (RsE == WriteRegM) && RegWriteM)      ForwardAE = 2'b10;
      else if ((RsE != 5'd0) && (RsE == WriteRegW) && RegWriteW) ForwardAE = 2'b01;
      if ((RtE != 5'd0) && (RtE == WriteRegM) && RegWriteM)      ForwardBE = 2'b10;
      else if ((RtE != 5'd0) && (RtE == WriteRegW) && RegWriteW) ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
      ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
    end
  end

  // Stall/flush priority: reset bubbles, then memory wait holds everything
  // (E is held, not flushed), then load-use/branch stalls the front end.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwstall || branchstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Memory-wait FSM next state: count consecutive wait cycles, trap on timeout.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    mem_err_nxt = mem_err;
    case (state)
      RUN: begin
        if (mem_pend) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = ERR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // Saturating event counters for StallD and FlushE cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushE && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside the control-unit pipeline registers and drives their FlushE input.
- Consumes the stage-tagged control bits and register numbers (RegWriteE/M/W, MemtoRegE/M, WriteRegE/M/W, Rs/Rt D/E) and produces forwarding selects, stalls and flushes.
- Adds a data-memory wait handshake FSM with timeout, plus saturating stall/flush event counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive memory-wait cycles before sticky error.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- RsD, RtD, RsE, RtE  in  5 each  source register numbers in D and E.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load indicators.
- MemWriteM  in  1  store in M.
- BranchD  in  1  branch in D.
- mem_ready  in  1  data memory completes the M-stage access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage registers.
- FlushE, FlushW  out  1 each  insert a bubble into the E / W registers.
- ForwardAD, ForwardBD  out  1 each  D-stage comparator forward from M.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 W, 10 M.
- mem_err  out  1  sticky memory timeout.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset (reset==0 at a rising edge): state<=RUN, wait_cnt<=0, mem_err<=0, both counters<=0.
  - While reset is low, outputs are StallF/D/E/M=0, FlushE=1, FlushW=1, forwards=0.
- Forwarding is combinational. Register 0 never matches.
  - ForwardAE=10 if RsE!=0 & RsE==WriteRegM & RegWriteM.
  - Otherwise ForwardAE=01 if RsE!=0 & RsE==WriteRegW & RegWriteW.
  - Otherwise ForwardAE=00. M has priority over W.
  - ForwardBE uses RtE with the same rules.
  - ForwardAD = RsD!=0 & RsD==WriteRegM & RegWriteM. ForwardBD uses RtD likewise.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & WriteRegM!=0 & (WriteRegM==RsD | WriteRegM==RtD))).
- memstall = (MemtoRegM | MemWriteM) & ~mem_ready, or state==ERR.
- Priority 1, memstall:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0.
  - The E contents are held, not flushed.
- Priority 2, lwstall | branchstall (no memstall):
  - StallF=StallD=FlushE=1, StallE=StallM=FlushW=0.
- Otherwise all stall and flush outputs are 0.
- FSM states: RUN, MEM_WAIT, ERR.
  - RUN: if memstall, go to MEM_WAIT and set wait_cnt<=1.
  - MEM_WAIT with mem_ready=1: go to RUN and set wait_cnt<=0. The stall drops combinationally in the same cycle mem_ready rises.
  - MEM_WAIT, still waiting, wait_cnt==MEM_TIMEOUT-1: go to ERR and set mem_err<=1.
  - MEM_WAIT, still waiting, otherwise: wait_cnt<=wait_cnt+1.
  - ERR: absorbing; all four stalls stay asserted until reset.
  - An access whose mem_ready arrives in the first M cycle never leaves RUN.
- Counters, updated at the clock edge:
  - stall_cnt increments on each cycle with StallD=1, whatever the source.
  - flush_cnt increments on each cycle with FlushE=1, outside reset.
  - Both saturate at 2^CNT_W-1; no wrap.
- Simultaneous lwstall and memstall: memstall wins. The load-use condition re-evaluates once memory completes.
- Reset during MEM_WAIT or ERR returns to RUN on that edge, with counters and mem_err cleared.

Test Plan:
- Forwarding: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set RsE=0 with the original values -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt=1 and flush_cnt=1 after the edge.
- Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> StallD=FlushE=1. Next cycle with WriteRegM=3, RegWriteM=1, MemtoRegM=0 -> no stall, ForwardAD=1.
- Memory wait: MemtoRegM=1, mem_ready=0 for 3 cycles, then 1 -> all four stalls and FlushW high for exactly 3 cycles, FlushE=0, state returns to RUN, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, MemWriteM=1, mem_ready held 0 -> mem_err=1 after the 4th wait cycle; stalls persist even after mem_ready=1. Drive reset=0 for one edge -> mem_err=0, counters 0.
- Saturation: CNT_W=3, hold lwstall for 10 cycles -> stall_cnt=7 and flush_cnt=7, both holding.
